// File: rtl/rr_arb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// rr_arb_pkg : shared defaults and FSM encoding for the rr_arbiter
// Revision   : 1.0
// ------------------------------------------------------------------
package rr_arb_pkg;

  localparam int N_DEF        = 10;
  localparam int IDW_DEF      = 4;
  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// rr_pick : lowest-index search over req at/above ptr, else over all req
// Revision : 1.0
// ------------------------------------------------------------------
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int IDW = IDW_DEF
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic           found,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] w_idx;

  // Descending scans: the last hit written is the lowest index. The masked
  // scan runs second so any hit at/above ptr overrides the unmasked one.
  always_comb begin
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) w_idx = IDW'(i);
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr))) w_idx = IDW'(i);
    end
  end

  assign found = |req;
  assign idx   = w_idx;

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ------------------------------------------------------------------
// rr_arbiter : N-way round-robin arbiter, bounded hold, one-cycle gap
// Revision   : 1.0
// ------------------------------------------------------------------
module rr_arbiter
  import rr_arb_pkg::*;
#(
  parameter int N        = N_DEF,
  parameter int IDW      = IDW_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           busy_any
);

  localparam logic [7:0]     c_HCNT_LAST = 8'(MAX_HOLD - 1);
  localparam logic [IDW-1:0] c_LAST_ID   = IDW'(N - 1);
  localparam logic [N-1:0]   c_ONE       = N'(1);

  state_t         r_state;
  logic [N-1:0]   r_gnt;
  logic [IDW-1:0] r_gnt_id;
  logic [IDW-1:0] r_ptr;
  logic [7:0]     r_hcnt;
  logic           r_gnt_valid;
  logic           r_busy_any;

  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic           w_hold_req;
  logic           w_others;
  logic           w_at_limit;
  logic           w_release;

  rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req   (req),
    .ptr   (r_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

  // Timeout only forces a release when someone else is actually waiting.
  assign w_hold_req = |(req & r_gnt);
  assign w_others   = |(req & ~r_gnt);
  assign w_at_limit = (r_hcnt == c_HCNT_LAST);
  assign w_release  = !w_hold_req || (w_at_limit && w_others);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt       <= '0;
      r_gnt_id    <= '0;
      r_gnt_valid <= 1'b0;
      r_ptr       <= '0;
      r_hcnt      <= '0;
      r_busy_any  <= 1'b0;
    end else begin
      r_busy_any <= |req;
      case (r_state)
        ST_GRANT: begin
          if (w_release) begin
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= (r_gnt_id == c_LAST_ID) ? '0 : r_gnt_id + IDW'(1);
            r_state     <= ST_GAP;
          end else if (!w_at_limit) begin
            r_hcnt <= r_hcnt + 8'd1;
          end
        end
        default: begin
          if (w_found) begin
            r_gnt       <= c_ONE << w_idx;
            r_gnt_id    <= w_idx;
            r_gnt_valid <= 1'b1;
            r_hcnt      <= '0;
            r_state     <= ST_GRANT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_id    = r_gnt_id;
  assign gnt_valid = r_gnt_valid;
  assign busy_any  = r_busy_any;

endmodule
`default_nettype wire
